// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : input_conditioner_if
//  Brief    : Pin-level inputs and conditioned outputs of input_conditioner.
//  Revision : 1.0
// ============================================================================
interface input_conditioner_if #(
    parameter int WIDTH = 14
) ();
    logic [WIDTH-1:0] raw_i;
    logic [WIDTH-1:0] edge_en_i;
    logic [WIDTH-1:0] edge_clr_i;
    logic [WIDTH-1:0] stable_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic [WIDTH-1:0] edge_cap_o;
    logic             irq_o;

    modport master (
        output raw_i, edge_en_i, edge_clr_i,
        input  stable_o, rise_o, fall_o, edge_cap_o, irq_o
    );

    modport slave (
        input  raw_i, edge_en_i, edge_clr_i,
        output stable_o, rise_o, fall_o, edge_cap_o, irq_o
    );
endinterface
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : input_conditioner
//  Brief    : Per-bit synchronizer, debounce, polarity fix, edge pulses and
//             sticky CPU-clearable edge capture with registered interrupt.
//  Revision : 1.0
// ============================================================================
module input_conditioner #(
    parameter int               WIDTH           = 14,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 250000,
    parameter logic [WIDTH-1:0] INVERT_MASK     = 14'h3C00
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input_conditioner_if.slave bus
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] level;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             irq_q, irq_d;

    // Active-high view of the synchronized pins
    assign level = sync_q[SYNC_STAGES-1] ^ INVERT_MASK;

    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (level[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = level[i];
                    rise_d[i]   = level[i];
                    fall_d[i]   = ~level[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // A pulse arriving together with a clear still leaves the bit set
        cap_d = (cap_q & ~bus.edge_clr_i) | rise_q | fall_q;
        irq_d = |(cap_q & bus.edge_en_i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= INVERT_MASK;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            cap_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync_q[0] <= bus.raw_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cap_q    <= cap_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.stable_o   = stable_q;
    assign bus.rise_o     = rise_q;
    assign bus.fall_o     = fall_q;
    assign bus.edge_cap_o = cap_q;
    assign bus.irq_o      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_conditioner
//  Brief    : Directed bench for input_conditioner with a window-based model.
//  Revision : 1.0
// ============================================================================
module tb_input_conditioner;

    localparam int          W   = 14;
    localparam int          SS  = 2;
    localparam int          DB  = 4;
    localparam logic [W-1:0] INV = 14'h3C00;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;

    input_conditioner_if #(.WIDTH(W)) bus ();

    input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .INVERT_MASK(INV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: a bit flips once its last DB sampled levels all disagree with it
    logic [W-1:0] m_pipe [SS];
    logic [W-1:0] m_win  [DB];
    logic [W-1:0] m_stable, m_rise, m_fall, m_cap;
    logic         m_irq;

    task automatic model_step(input logic rn);
        logic [W-1:0] s_now, all_diff, nstable;
        if (!rn) begin
            for (int k = 0; k < SS; k++) m_pipe[k] = INV;
            for (int k = 0; k < DB; k++) m_win[k] = '0;
            m_stable = '0; m_rise = '0; m_fall = '0; m_cap = '0; m_irq = 1'b0;
        end else begin
            s_now = m_pipe[SS-1] ^ INV;
            for (int k = SS-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = bus.raw_i;
            for (int k = DB-1; k > 0; k--) m_win[k] = m_win[k-1];
            m_win[0] = s_now;
            all_diff = '1;
            for (int k = 0; k < DB; k++) all_diff &= (m_win[k] ^ m_stable);
            m_irq    = |(m_cap & bus.edge_en_i);
            m_cap    = (m_cap & ~bus.edge_clr_i) | m_rise | m_fall;
            nstable  = m_stable ^ all_diff;
            m_rise   = all_diff & nstable;
            m_fall   = all_diff & ~nstable;
            m_stable = nstable;
        end
    endtask

    always @(posedge clk or negedge reset_n) model_step(reset_n);

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("model stable_o",   bus.stable_o,   m_stable);
        chk("model rise_o",     bus.rise_o,     m_rise);
        chk("model fall_o",     bus.fall_o,     m_fall);
        chk("model edge_cap_o", bus.edge_cap_o, m_cap);
        chk("model irq_o",      {13'b0, bus.irq_o}, {13'b0, m_irq});
    endtask

    always @(negedge clk) if (run) compare_all();

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.raw_i      = INV;
        bus.edge_en_i  = '0;
        bus.edge_clr_i = '0;

        // 1: reset state and idle hold
        cycles(3);
        run = 1'b1;
        chk("reset stable_o", bus.stable_o, '0);
        chk("reset edge_cap_o", bus.edge_cap_o, '0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            chk("idle pulses", bus.rise_o | bus.fall_o | bus.stable_o, '0);
        end
        chk("idle irq_o", {13'b0, bus.irq_o}, '0);

        // 2: clean rise of SW0, 6-edge latency
        bus.raw_i = 14'h3C01;
        for (int i = 1; i <= 6; i++) begin
            cycles(1);
            chk("t2 stable_o[0]", {13'b0, bus.stable_o[0]}, {13'b0, (i == 6)});
        end
        chk("t2 rise_o[0]", {13'b0, bus.rise_o[0]}, 14'd1);
        cycles(1);
        chk("t2 rise_o one cycle", {13'b0, bus.rise_o[0]}, 14'd0);
        chk("t2 edge_cap_o[0]", {13'b0, bus.edge_cap_o[0]}, 14'd1);

        // 3: return low, then glitch train must be rejected
        bus.raw_i = INV;
        cycles(10);
        chk("t3 settled low", {13'b0, bus.stable_o[0]}, 14'd0);
        for (int i = 0; i < 18; i++) begin
            bus.raw_i = (i < 8 && i != 3 && i != 7) ? 14'h3C01 : INV;
            cycles(1);
            chk("t3 glitch stable", {13'b0, bus.stable_o[0]}, 14'd0);
            chk("t3 glitch pulses", {13'b0, bus.rise_o[0] | bus.fall_o[0]}, 14'd0);
        end

        // 4: KEY3 press (active low) and release
        bus.raw_i = 14'h1C00;
        for (int i = 1; i <= 6; i++) begin
            cycles(1);
            chk("t4 stable_o[13]", {13'b0, bus.stable_o[13]}, {13'b0, (i == 6)});
        end
        bus.raw_i = INV;
        for (int i = 1; i <= 6; i++) begin
            cycles(1);
            chk("t4 fall_o[13]", {13'b0, bus.fall_o[13]}, {13'b0, (i == 6)});
        end

        // 5: clear colliding with a new rise, then clear alone
        bus.edge_en_i = 14'h0001;
        cycles(2);
        chk("t5 irq before", {13'b0, bus.irq_o}, 14'd1);
        bus.raw_i = 14'h3C01;
        cycles(6);
        chk("t5 rise_o[0]", {13'b0, bus.rise_o[0]}, 14'd1);
        bus.edge_clr_i = 14'h0001;
        cycles(1);
        chk("t5 cap kept", {13'b0, bus.edge_cap_o[0]}, 14'd1);
        chk("t5 irq kept", {13'b0, bus.irq_o}, 14'd1);
        cycles(1);
        chk("t5 cap cleared", {13'b0, bus.edge_cap_o[0]}, 14'd0);
        chk("t5 irq lag", {13'b0, bus.irq_o}, 14'd1);
        bus.edge_clr_i = '0;
        cycles(1);
        chk("t5 irq dropped", {13'b0, bus.irq_o}, 14'd0);

        // 6: reset while the SW0 counter sits at 2
        bus.raw_i = INV;
        cycles(10);
        bus.raw_i = 14'h3C01;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6 reset stable_o", bus.stable_o, '0);
        chk("t6 reset edge_cap_o", bus.edge_cap_o, '0);
        chk("t6 reset irq_o", {13'b0, bus.irq_o}, '0);
        cycles(3);
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cycles(1);
            chk("t6 stable_o[0]", {13'b0, bus.stable_o[0]}, {13'b0, (i == 6)});
        end

        // 7: every bit changing at once
        bus.raw_i = 14'h03FF;
        cycles(5);
        chk("t7 before", bus.stable_o, 14'h0001);
        cycles(1);
        chk("t7 all stable", bus.stable_o, 14'h3FFF);
        chk("t7 all rise", bus.rise_o, 14'h3FFE);
        bus.raw_i = INV;
        cycles(8);
        chk("t7 all low", bus.stable_o, 14'h0000);

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
